sw_matrix_sink: RTL and testbench

//   Receiving end of the PE-array matrix write port. Captures 16-lane score rows (W_matrix/addr_matrix_o/matrix_o0..15)

---
 rtl/sw_matrix_sink_if.sv | 26 ++
 rtl/sw_matrix_sink.sv | 177 +++++++++++++++++
 tb/tb_sw_matrix_sink.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sw_matrix_sink_if.sv
// Write/read port bundle between the PE array, the host and sw_matrix_sink.
// The array/host side uses the master modport; the sink uses slave.
interface sw_matrix_sink_if #(
    parameter int DEPTH   = 31,
    parameter int LANES   = 16,
    parameter int SCORE_W = 32
);
    localparam int AW = $clog2(DEPTH);

    logic                     wr_en_i;
    logic [31:0]              wr_addr_i;
    logic [LANES*SCORE_W-1:0] wr_data_i;
    logic                     rd_req_i;
    logic [AW-1:0]            rd_addr_i;
    logic                     rd_valid_o;
    logic [LANES*SCORE_W-1:0] rd_data_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
        input  rd_valid_o, rd_data_o
    );
    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
        output rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/sw_matrix_sink.sv
// Score-row sink: row buffer, global max/location tracking, host read-back.
// Optional SW_SINK_PIPE_EN registers the lane-max reduction (+1 cycle max latency).
module sw_matrix_sink #(
    parameter int DEPTH   = 31,
    parameter int LANES   = 16,
    parameter int SCORE_W = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int RW     = LANES * SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               full_i,
    sw_matrix_sink_if.slave    bus,
    output logic [SCORE_W-1:0] max_score_o,
    output logic [AW-1:0]      max_row_o,
    output logic [3:0]         max_lane_o,
    output logic [15:0]        row_cnt_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ovf_o
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

    state_t r_state, w_next;

    logic                          r_full_d;
    logic                          w_rise;
    logic                          w_addr_ok;
    logic                          w_wr_hit;
    logic                          w_acc;
    logic [AW-1:0]                 w_row;
    logic [LANES-1:0][SCORE_W-1:0] w_lanes;
    logic [SCORE_W-1:0]            w_rmax;
    logic [3:0]                    w_rlane;
    logic                          w_c_vld;
    logic [SCORE_W-1:0]            w_c_max;
    logic [AW-1:0]                 w_c_row;
    logic [3:0]                    w_c_lane;
    logic                          w_rd_ok;

    logic [RW-1:0]    r_ram [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [RW-1:0]    r_rd_data;
    logic             r_rd_valid;

    assign w_rise    = full_i & ~r_full_d;
    assign w_addr_ok = bus.wr_addr_i < 32'(DEPTH);
    assign w_wr_hit  = bus.wr_en_i & ~clear_i & (r_state == S_IDLE || r_state == S_CAPTURE);
    assign w_acc     = w_wr_hit & w_addr_ok;
    assign w_row     = bus.wr_addr_i[AW-1:0];
    assign w_lanes   = bus.wr_data_i;

    // Strict '>' keeps the lowest lane on ties.
    always_comb begin
        w_rmax  = w_lanes[0];
        w_rlane = '0;
        for (int l = 1; l < LANES; l++) begin
            if (w_lanes[l] > w_rmax) begin
                w_rmax  = w_lanes[l];
                w_rlane = 4'(l);
            end
        end
    end

`ifdef SW_SINK_PIPE_EN
    logic               r_c_vld;
    logic [SCORE_W-1:0] r_c_max;
    logic [AW-1:0]      r_c_row;
    logic [3:0]         r_c_lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_vld  <= 1'b0;
            r_c_max  <= '0;
            r_c_row  <= '0;
            r_c_lane <= '0;
        end else begin
            r_c_vld  <= w_acc;
            r_c_max  <= w_rmax;
            r_c_row  <= w_row;
            r_c_lane <= w_rlane;
        end
    end

    // Clear drops a reduction still in flight.
    assign w_c_vld  = r_c_vld & ~clear_i;
    assign w_c_max  = r_c_max;
    assign w_c_row  = r_c_row;
    assign w_c_lane = r_c_lane;
`else
    assign w_c_vld  = w_acc;
    assign w_c_max  = w_rmax;
    assign w_c_row  = w_row;
    assign w_c_lane = w_rlane;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.wr_en_i) w_next = S_CAPTURE;
`ifdef SW_SINK_PIPE_EN
            S_CAPTURE: if (w_rise) w_next = S_FLUSH;
`else
            S_CAPTURE: if (w_rise) w_next = S_DONE;
`endif
            S_FLUSH:   w_next = S_DONE;
            default:   w_next = r_state;
        endcase
        if (clear_i) w_next = S_IDLE;
    end

    always_comb begin
        busy_o = (r_state == S_CAPTURE) || (r_state == S_FLUSH);
        done_o = (r_state == S_DONE);
    end

    // Reset to 1 so a level already high when reset drops is not taken as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_full_d <= 1'b1;
        else     r_full_d <= full_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_score_o <= '0;
            max_row_o   <= '0;
            max_lane_o  <= '0;
            row_cnt_o   <= '0;
            ovf_o       <= 1'b0;
            r_valid     <= '0;
        end else if (clear_i) begin
            max_score_o <= '0;
            max_row_o   <= '0;
            max_lane_o  <= '0;
            row_cnt_o   <= '0;
            ovf_o       <= 1'b0;
            r_valid     <= '0;
        end else begin
            if (w_c_vld && w_c_max > max_score_o) begin
                max_score_o <= w_c_max;
                max_row_o   <= w_c_row;
                max_lane_o  <= w_c_lane;
            end
            if (w_acc) begin
                r_valid[w_row] <= 1'b1;
                if (row_cnt_o != 16'hFFFF) row_cnt_o <= row_cnt_o + 16'd1;
            end
            if (w_wr_hit && !w_addr_ok) ovf_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) r_ram[w_row] <= bus.wr_data_i;
    end

    assign w_rd_ok = (bus.rd_addr_i < AW'(DEPTH)) && r_valid[bus.rd_addr_i];

    // Non-blocking RAM read yields the pre-write row on a same-cycle collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= bus.rd_req_i;
            if (bus.rd_req_i) r_rd_data <= w_rd_ok ? r_ram[bus.rd_addr_i] : '0;
        end
    end

    assign bus.rd_valid_o = r_rd_valid;
    assign bus.rd_data_o  = r_rd_data;
endmodule

// File: tb/tb_sw_matrix_sink.sv
// Scoreboard bench for sw_matrix_sink: read expectations queued at request,
// popped when rd_valid_o fires; status outputs checked against fixed values.
module tb_sw_matrix_sink;
    localparam int DEPTH = 31;
    localparam int LANES = 16;
    localparam int SW    = 32;
    localparam int AW    = 5;
    localparam int RW    = LANES * SW;
`ifdef SW_SINK_PIPE_EN
    localparam int MLAT = 2;
    localparam int DLAT = 2;
`else
    localparam int MLAT = 1;
    localparam int DLAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic full = 1'b0;
    logic [SW-1:0] max_score;
    logic [AW-1:0] max_row;
    logic [3:0]    max_lane;
    logic [15:0]   row_cnt;
    logic          busy, done, ovf;

    sw_matrix_sink_if #(.DEPTH(DEPTH), .LANES(LANES), .SCORE_W(SW)) sif();

    sw_matrix_sink dut (
        .clk(clk), .rst(rst), .clear_i(clear), .full_i(full), .bus(sif.slave),
        .max_score_o(max_score), .max_row_o(max_row), .max_lane_o(max_lane),
        .row_cnt_o(row_cnt), .busy_o(busy), .done_o(done), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [RW-1:0] act, logic [RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [RW-1:0] m_mem [DEPTH];
    bit            m_vld [DEPTH];
    logic [RW-1:0] sb_q [$];
    logic [RW-1:0] mon_exp;

    function automatic logic [RW-1:0] mk_row(int r);
        logic [RW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*SW +: SW] = SW'(r + l);
        return v;
    endfunction

    function automatic logic [RW-1:0] fill(int x);
        logic [RW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*SW +: SW] = SW'(x);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++) m_vld[r] = 1'b0;
    endtask

    // One cycle of port activity; acc says whether the bench expects the write stored.
    task automatic cyc(bit we, int wa, logic [RW-1:0] wd, bit rd, int ra, bit acc);
        sif.wr_en_i   = we;
        sif.wr_addr_i = 32'(wa);
        sif.wr_data_i = wd;
        sif.rd_req_i  = rd;
        sif.rd_addr_i = AW'(ra);
        if (rd) begin
            if (ra < DEPTH && m_vld[ra]) sb_q.push_back(m_mem[ra]);
            else                         sb_q.push_back('0);
        end
        tick();
        if (we && acc) begin
            m_mem[wa] = wd;
            m_vld[wa] = 1'b1;
        end
        sif.wr_en_i  = 1'b0;
        sif.rd_req_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && sif.rd_valid_o) begin
            if (sb_q.size() == 0) chk("rd_spurious", 1, 0);
            else begin
                mon_exp = sb_q.pop_front();
                chk("rd_data", sif.rd_data_o, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout expected none");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] v;
        sif.wr_en_i = 0; sif.wr_addr_i = 0; sif.wr_data_i = '0;
        sif.rd_req_i = 0; sif.rd_addr_i = '0;
        model_clear();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_max", max_score, 0);
        chk("rst_row", max_row, 0);
        chk("rst_lane", max_lane, 0);
        chk("rst_cnt", row_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_rdv", sif.rd_valid_o, 0);

        // Reset in the middle of a capture
        for (int r = 0; r < 3; r++) cyc(1, r, mk_row(r + 1), 0, 0, 1);
        chk("t1_busy", busy, 1);
        chk("t1_cnt", row_cnt, 3);
        #2 rst = 1'b1;
        #1;
        model_clear();
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_max", max_score, 0);
        chk("t1_rst_cnt", row_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        cyc(0, 0, '0, 1, 1, 0);
        tick();
        chk("t1_rd_pulse", sif.rd_valid_o, 0);

        // Full matrix then matrix_full edge
        for (int r = 0; r < DEPTH; r++) cyc(1, r, mk_row(r), 0, 0, 1);
        full = 1'b1;
        tick();
        for (int i = 1; i < DLAT; i++) begin
            chk("t2_done_early", done, 0);
            tick();
        end
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        chk("t2_max", max_score, 45);
        chk("t2_row", max_row, 30);
        chk("t2_lane", max_lane, 15);
        chk("t2_cnt", row_cnt, 31);

        // Writes in DONE are ignored; read-back still served
        cyc(1, 2, fill(500), 0, 0, 0);
        chk("t5_cnt", row_cnt, 31);
        cyc(0, 0, '0, 1, 2, 0);
        tick();
        chk("t5_rd_pulse", sif.rd_valid_o, 0);
        chk("t5_max", max_score, 45);

        clear = 1'b1;
        full  = 1'b0;
        tick();
        clear = 1'b0;
        model_clear();
        chk("clr_done", done, 0);
        chk("clr_max", max_score, 0);
        chk("clr_cnt", row_cnt, 0);

        // Tie rules: lowest lane within a row, earliest row across rows
        v = '0;
        v[3*SW +: SW] = 77;
        v[9*SW +: SW] = 77;
        cyc(1, 5, v, 0, 0, 1);
        for (int i = 1; i < MLAT; i++) tick();
        chk("t3_max_lat", max_score, 77);
        v = '0;
        v[0 +: SW] = 77;
        cyc(1, 8, v, 0, 0, 1);
        repeat (MLAT) tick();
        chk("t3_max", max_score, 77);
        chk("t3_row", max_row, 5);
        chk("t3_lane", max_lane, 3);

        // Out-of-range address
        cyc(1, 31, fill(99), 0, 0, 0);
        repeat (MLAT) tick();
        chk("t4_ovf", ovf, 1);
        chk("t4_cnt", row_cnt, 2);
        chk("t4_max", max_score, 77);
        chk("t4_row", max_row, 5);

        // Read-before-write collision, unwritten and out-of-range reads
        cyc(1, 4, fill(3), 0, 0, 1);
        cyc(1, 4, fill(7), 1, 4, 1);
        cyc(0, 0, '0, 1, 4, 0);
        cyc(0, 0, '0, 1, 6, 0);
        cyc(0, 0, '0, 1, 31, 0);
        tick();
        chk("t6_cnt", row_cnt, 4);
        chk("t6_ovf_sticky", ovf, 1);

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) tick();
        chk("sb_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
